// File: rtl/factor_search_pkg.sv
// rtl/factor_search_pkg.sv - shared types and constants for the factor search sequencer
package factor_search_pkg;

    localparam int DEFAULT_W  = 5;
    localparam int MIN_FACTOR = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int tgt_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/factor_search_ctrl_mul.sv
// rtl/factor_search_ctrl_mul.sv - W-cycle shift-add multiplier; prod is final the cycle after done
module seq_shift_add_mul
    import factor_search_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   prod,
    output logic             done
);

    localparam int PW = tgt_width(W);
    localparam int CW = $clog2(W + 1);

    logic [PW-1:0] mcand_q;
    logic [PW-1:0] acc_q;
    logic [W-1:0]  mplier_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (!run_q && go) begin
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(W);
            run_q    <= 1'b1;
        end else if (run_q) begin
            // one partial product per cycle, LSB of the multiplier first
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done = run_q && (cnt_q == CW'(1));
    assign prod = acc_q;

endmodule

// File: rtl/factor_search_ctrl.sv
// rtl/factor_search_ctrl.sv - enumerates (x, y) candidate pairs and reports the first factorization
module factor_search_ctrl
    import factor_search_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*W-1:0]   target,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [W-1:0]     f1,
    output logic [W-1:0]     f2,
    output logic [CNT_W-1:0] cand_count
);

    localparam int           TW      = tgt_width(W);
    localparam logic [W-1:0] F_MAX   = {W{1'b1}};
    localparam logic [W-1:0] F_MIN   = W'(MIN_FACTOR);
    localparam logic [TW-1:0] TGT_MIN = TW'(MIN_FACTOR * MIN_FACTOR);

    state_t          state_q, state_d;
    logic [TW-1:0]   tgt_q;
    logic [W-1:0]    x_q, x_d, y_q, y_d;
    logic            mul_go, mul_done, hit;
    logic [TW-1:0]   prod;

    seq_shift_add_mul #(.W(W)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .go   (mul_go),
        .a    (x_d),
        .b    (y_d),
        .prod (prod),
        .done (mul_done)
    );

    // operands go to the multiplier from the next-state values so a relaunch needs no extra cycle
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mul_go  = 1'b0;
        hit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (tgt_q < TGT_MIN) begin
                    state_d = S_DONE;
                end else begin
                    x_d     = F_MIN;
                    y_d     = F_MIN;
                    mul_go  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_done) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (prod == tgt_q) begin
                    hit     = 1'b1;
                    state_d = S_DONE;
                end else if (prod > tgt_q && y_q == x_q) begin
                    state_d = S_DONE;
                end else if (prod > tgt_q || y_q == F_MAX) begin
                    if (x_q == F_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        x_d     = x_q + 1'b1;
                        y_d     = x_q + 1'b1;
                        mul_go  = 1'b1;
                        state_d = S_MUL;
                    end
                end else begin
                    y_d     = y_q + 1'b1;
                    mul_go  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tgt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            found      <= 1'b0;
            f1         <= '0;
            f2         <= '0;
            cand_count <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (state_q == S_IDLE && start) begin
                tgt_q      <= target;
                found      <= 1'b0;
                f1         <= '0;
                f2         <= '0;
                cand_count <= '0;
            end
            if (state_q == S_CHECK) begin
                if (cand_count != {CNT_W{1'b1}}) begin
                    cand_count <= cand_count + 1'b1;
                end
                if (hit) begin
                    found <= 1'b1;
                    f1    <= x_q;
                    f2    <= y_q;
                end
            end
        end
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_factor_search_ctrl.sv
// tb/tb_factor_search_ctrl.sv - scoreboard bench for factor_search_ctrl
module tb_factor_search_ctrl;

    localparam int W     = 5;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2*W-1:0]   target;
    logic             busy, done, found;
    logic [W-1:0]     f1, f2;
    logic [CNT_W-1:0] cand_count;

    factor_search_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .target     (target),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .f1         (f1),
        .f2         (f2),
        .cand_count (cand_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tgt;
        int found;
        int f1;
        int f2;
        int cnt;
        int done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    exp_t mon_e;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            chk("done_pulse_width", int'(prev_done), 0);
            chk("busy_in_done", int'(busy), 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("found", int'(found), mon_e.found);
                chk("f1", int'(f1), mon_e.f1);
                chk("f2", int'(f2), mon_e.f2);
                if (mon_e.cnt >= 0) chk("cand_count", int'(cand_count), mon_e.cnt);
                if (mon_e.done_cyc >= 0) chk("done_cycle", cyc, mon_e.done_cyc);
                if (mon_e.found == 1) chk("f1_times_f2", int'(f1) * int'(f2), mon_e.tgt);
            end
        end
        prev_done = done;
    end

    task automatic search(input int t, input int ef, input int e1, input int e2,
                          input int ecnt, input bit timed, input int glitch_at);
        exp_t e;
        bit   got;
        @(negedge clk);
        e.tgt      = t;
        e.found    = ef;
        e.f1       = e1;
        e.f2       = e2;
        e.cnt      = ecnt;
        e.done_cyc = timed ? (cyc + 1) + 1 + ecnt * (W + 1) : -1;
        sb_q.push_back(e);
        start  = 1'b1;
        target = (2*W)'(t);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = (i == glitch_at);
            if (i == glitch_at) target = 10'd15;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic ref_model(input int t, output int ef, output int e1, output int e2);
        ef = 0;
        e1 = 0;
        e2 = 0;
        for (int x = 2; x <= 31; x++) begin
            if (ef == 0 && t % x == 0 && t / x >= x && t / x <= 31) begin
                ef = 1;
                e1 = x;
                e2 = t / x;
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_found"}, int'(found), 0);
        chk({tag, "_f1"}, int'(f1), 0);
        chk({tag, "_f2"}, int'(f2), 0);
        chk({tag, "_cand_count"}, int'(cand_count), 0);
    endtask

    initial begin
        int rt, rf, r1, r2;
        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero_outputs("reset");

        search(15,   1, 3,  5,  10,  1'b1, -1);
        search(13,   0, 0,  0,  10,  1'b1, -1);
        search(3,    0, 0,  0,  0,   1'b1, -1);
        search(0,    0, 0,  0,  0,   1'b1, -1);
        search(4,    1, 2,  2,  1,   1'b1, -1);
        search(62,   1, 2,  31, 30,  1'b1, -1);
        search(961,  1, 31, 31, 465, 1'b1, -1);
        search(1023, 0, 0,  0,  465, 1'b1, -1);

        // abort a search with reset; any done pulse would hit an empty scoreboard
        @(negedge clk);
        start  = 1'b1;
        target = 10'd15;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero_outputs("abort");
        repeat (80) @(negedge clk);

        search(6, 1, 2, 3, 2, 1'b1, 3);
        repeat (30) @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            rt = int'($urandom_range(0, 1023));
            ref_model(rt, rf, r1, r2);
            search(rt, rf, r1, r2, -1, 1'b0, -1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
